seg7_display_sched: RTL

//  Time-multiplexed 4-digit 7-segment display controller for the reaction-timer board.

---
 rtl/seg7_sched_if.sv | 34 +++
 rtl/seg7_display_sched.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_sched_if.sv
// ---------------------------------------------------------------------------
// seg7_sched_if
//  Bundles the requester side and display side of seg7_display_sched.
//  master : requester / board side (drives background and message inputs)
//  slave  : the display scheduler itself
//  Signals:
//   bg_en, bg_data[15:0]      background source (level request + digits)
//   msg_valid, msg_data[15:0] message request, accepted when msg_ready=1
//   msg_ready                 message can be accepted this cycle
//   msg_clear                 terminate the current message early
//   active_src[1:0]           00 none, 01 background, 10 message
//   seg[6:0], an[3:0]         active-low segments {g..a} and anodes
// ---------------------------------------------------------------------------
interface seg7_sched_if;
   logic        bg_en;
   logic [15:0] bg_data;
   logic        msg_valid;
   logic [15:0] msg_data;
   logic        msg_ready;
   logic        msg_clear;
   logic [1:0]  active_src;
   logic [6:0]  seg;
   logic [3:0]  an;

   modport master (
      output bg_en, bg_data, msg_valid, msg_data, msg_clear,
      input  msg_ready, active_src, seg, an
   );

   modport slave (
      input  bg_en, bg_data, msg_valid, msg_data, msg_clear,
      output msg_ready, active_src, seg, an
   );
endinterface

// File: rtl/seg7_display_sched.sv
// ---------------------------------------------------------------------------
// seg7_display_sched
//  Time-multiplexed 4-digit 7-segment controller shared between a continuous
//  background source and a valid/ready message source that owns the display
//  for HOLD_CYCLES clocks (or until msg_clear). Content is latched only at
//  frame boundaries so a digit scan never mixes two sources.
//  Ports:
//   clk    in  system clock
//   reset  in  asynchronous, active-high reset
//   bus    seg7_sched_if.slave (requests in, msg_ready/active_src/seg/an out)
//  Parameters:
//   REFRESH_DIV  clk cycles per digit dwell (>=2)
//   HOLD_CYCLES  clk cycles a message owns the display (>=1)
//   LZ_SUPPRESS  1: blank leading zero digits of background frames
// ---------------------------------------------------------------------------
module seg7_display_sched #(
   parameter int REFRESH_DIV = 100_000,
   parameter int HOLD_CYCLES = 200_000_000,
   parameter bit LZ_SUPPRESS = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   seg7_sched_if.slave  bus
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);

   // Encoding doubles as the active_src code.
   typedef enum logic [1:0] {
      S_NONE = 2'b00,
      S_BG   = 2'b01,
      S_MSG  = 2'b10
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic            r_msg_ready;
   logic [HW-1:0]   r_hold_cnt;
   logic [15:0]     r_msg_reg;
   logic            w_accept;
   logic            w_hold_done;

   logic [PW-1:0]   r_presc;
   logic [1:0]      r_idx;
   logic            w_tick;

   logic [15:0]     r_frame_data;
   logic            r_frame_blank;
   logic            r_frame_bg;

   logic [3:0]      w_nib;
   logic [3:0]      w_zero_from;
   logic            w_suppress;
   logic [6:0]      r_seg;
   logic [3:0]      r_an;

   // -------------------------------------------------------------------
   // hex nibble -> active-low {g,f,e,d,c,b,a}
   // -------------------------------------------------------------------
   function automatic logic [6:0] hexdec(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // -------------------------------------------------------------------
   // Owner FSM
   // -------------------------------------------------------------------
   // msg_ready is only ever high outside S_MSG, so an accept can only
   // happen from S_NONE or S_BG and always wins over bg_en.
   assign w_accept    = bus.msg_valid && r_msg_ready;
   assign w_hold_done = (r_hold_cnt == '0);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_NONE: begin
            if (w_accept)        w_next = S_MSG;
            else if (bus.bg_en)  w_next = S_BG;
         end
         S_BG: begin
            if (w_accept)        w_next = S_MSG;
            else if (!bus.bg_en) w_next = S_NONE;
         end
         S_MSG: begin
            if (bus.msg_clear || w_hold_done)
               w_next = bus.bg_en ? S_BG : S_NONE;
         end
         default: w_next = S_NONE;
      endcase
   end

   // hold_cnt is loaded with HOLD_CYCLES-1 and the exit fires on the
   // clock where it reads 0, giving exactly HOLD_CYCLES clocks in S_MSG.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_NONE;
         r_msg_ready <= 1'b0;
         r_hold_cnt  <= '0;
         r_msg_reg   <= '0;
      end else begin
         r_state     <= w_next;
         r_msg_ready <= (w_next != S_MSG);
         if (w_accept) begin
            r_msg_reg  <= bus.msg_data;
            r_hold_cnt <= HOLD_LOAD;
         end else if (r_state == S_MSG && !w_hold_done) begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
         end
      end
   end

   assign bus.msg_ready  = r_msg_ready;
   assign bus.active_src = r_state;

   // -------------------------------------------------------------------
   // Digit scan
   // -------------------------------------------------------------------
   assign w_tick = (r_presc == PRESC_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_presc <= '0;
         r_idx   <= 2'd0;
      end else begin
         r_presc <= w_tick ? '0 : r_presc + 1'b1;
         if (w_tick) r_idx <= r_idx + 2'd1;
      end
   end

   // -------------------------------------------------------------------
   // Frame latch: content only changes as digit 3 hands over to digit 0
   // -------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_frame_data  <= '0;
         r_frame_blank <= 1'b1;
         r_frame_bg    <= 1'b0;
      end else if (w_tick && r_idx == 2'd3) begin
         case (r_state)
            S_MSG: begin
               r_frame_data  <= r_msg_reg;
               r_frame_blank <= 1'b0;
               r_frame_bg    <= 1'b0;
            end
            S_BG: begin
               r_frame_data  <= bus.bg_data;
               r_frame_blank <= 1'b0;
               r_frame_bg    <= 1'b1;
            end
            default: begin
               r_frame_data  <= '0;
               r_frame_blank <= 1'b1;
               r_frame_bg    <= 1'b0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------
   // Output stage
   // -------------------------------------------------------------------
   assign w_nib = r_frame_data[{r_idx, 2'b00} +: 4];

   // w_zero_from[i]: digit i and every digit above it are zero.
   always_comb begin
      w_zero_from[3] = (r_frame_data[15:12] == 4'h0);
      for (int i = 2; i >= 0; i--)
         w_zero_from[i] = (r_frame_data[i*4 +: 4] == 4'h0) && w_zero_from[i+1];
   end

   // Digit 0 is never suppressed so a zero reading still shows "0".
   assign w_suppress = LZ_SUPPRESS && r_frame_bg && (r_idx != 2'd0)
                       && w_zero_from[r_idx];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_seg <= 7'h7F;
         r_an  <= 4'hF;
      end else if (r_frame_blank || w_suppress) begin
         r_seg <= 7'h7F;
         r_an  <= 4'hF;
      end else begin
         r_seg <= hexdec(w_nib);
         r_an  <= ~(4'b0001 << r_idx);
      end
   end

   assign bus.seg = r_seg;
   assign bus.an  = r_an;

endmodule
